// File: rtl/plru_pkg.sv
// Tree-PLRU helper package: heap-order index helpers and node range functions.
// A node at heap index k sits on level floor(log2(k+1)) and covers a contiguous
// block of ways; its lower child covers the first half, its upper child the rest.
package plru_pkg;

    // Level of heap node k (root is level 0).
    function automatic int node_level(input int k);
        return $clog2(k + 2) - 1;
    endfunction

    // Number of ways covered by node k in a tree over num_way ways.
    function automatic int node_size(input int k, input int num_way);
        return num_way >> node_level(k);
    endfunction

    // Lowest way index covered by node k.
    function automatic int node_lo(input int k, input int num_way);
        return (k + 1 - (1 << node_level(k))) * node_size(k, num_way);
    endfunction

    // Highest way index covered by node k.
    function automatic int node_hi(input int k, input int num_way);
        return node_lo(k, num_way) + node_size(k, num_way) - 1;
    endfunction

    function automatic int child_lo(input int k);
        return 2 * k + 1;
    endfunction

    function automatic int child_hi(input int k);
        return 2 * k + 2;
    endfunction

    function automatic int parent(input int k);
        return (k - 1) / 2;
    endfunction

endpackage

// File: rtl/plru_tree_pick.sv
// Combinational victim picker: invalid-first among unlocked ways, otherwise a
// tree walk that steers away from fully locked subtrees. Returns a one-hot way,
// or all zeros when every way is locked.
module plru_tree_pick
    import plru_pkg::*;
#(
    parameter int NUM_WAY = 4
) (
    input  logic [NUM_WAY-2:0] tree,
    input  logic [NUM_WAY-1:0] valid,
    input  logic [NUM_WAY-1:0] lock,
    output logic [NUM_WAY-1:0] way
);
    localparam int WAY_W = $clog2(NUM_WAY);

    logic [NUM_WAY-1:0] avail;
    logic [NUM_WAY-1:0] free;
    logic               lo_av;
    logic               hi_av;
    logic               go_hi;
    int                 node;
    int                 lo;
    int                 size;
    int                 half;

    // Choose the victim: lowest free unlocked way, else walk the tree.
    always_comb begin
        avail = ~lock;
        free  = avail & ~valid;
        way   = '0;
        lo_av = 1'b0;
        hi_av = 1'b0;
        go_hi = 1'b0;
        node  = 0;
        lo    = 0;
        size  = NUM_WAY;
        half  = NUM_WAY / 2;
        if (|free) begin
            for (int w = 0; w < NUM_WAY; w++) begin
                if (free[w] && (way == '0)) way[w] = 1'b1;
            end
        end else if (|avail) begin
            for (int l = 0; l < WAY_W; l++) begin
                half  = size / 2;
                lo_av = 1'b0;
                hi_av = 1'b0;
                for (int w = 0; w < NUM_WAY; w++) begin
                    if (w >= lo && w < lo + half)          lo_av = lo_av | avail[w];
                    if (w >= lo + half && w < lo + size)   hi_av = hi_av | avail[w];
                end
                // Preferred side is the bit's choice unless it is fully locked.
                go_hi = tree[node] ? hi_av : !lo_av;
                if (go_hi) begin
                    lo   = lo + half;
                    node = child_hi(node);
                end else begin
                    node = child_lo(node);
                end
                size = half;
            end
            way[lo] = 1'b1;
        end
    end

endmodule

// File: rtl/plru_repl_bank.sv
// Multi-set tree-PLRU replacement bank. Holds NUM_WAY-1 tree bits per set,
// applies touch updates, and answers victim lookups one cycle later with the
// same-cycle update (or flush) forwarded into the lookup.
// Optional feature macro: PLRU_WAY_LOCK_EN adds lkp_lock / vic_none.
module plru_repl_bank
    import plru_pkg::*;
#(
    parameter int NUM_WAY = 4,
    parameter int NUM_SET = 16,
    parameter int WAY_W   = $clog2(NUM_WAY),
    parameter int SET_W   = (NUM_SET > 1) ? $clog2(NUM_SET) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               upd_en,
    input  logic [SET_W-1:0]   upd_set,
    input  logic [NUM_WAY-1:0] upd_way,
    input  logic               lkp_en,
    input  logic [SET_W-1:0]   lkp_set,
    input  logic [NUM_WAY-1:0] lkp_valid,
    output logic               vic_vld,
    output logic [NUM_WAY-1:0] vic_way,
    output logic [WAY_W-1:0]   vic_idx
`ifdef PLRU_WAY_LOCK_EN
    ,
    input  logic [NUM_WAY-1:0] lkp_lock,
    output logic               vic_none
`endif
);
    typedef logic [NUM_WAY-2:0] tree_t;

    tree_t              tree_q [NUM_SET];
    tree_t              cur_tree;
    tree_t              upd_tree;
    tree_t              lkp_tree;
    logic               upd_ok;
    logic               lkp_ok;
    logic               lo_hit;
    logic               hi_hit;
    logic [NUM_WAY-1:0] lock;
    logic [NUM_WAY-1:0] pick_way;
    logic [NUM_WAY-1:0] sel_way;
    logic [WAY_W-1:0]   sel_idx;

`ifdef PLRU_WAY_LOCK_EN
    assign lock = lkp_lock;
`else
    assign lock = '0;
`endif

    // Indices past NUM_SET (non power-of-two bank) are treated as absent sets.
    assign upd_ok = int'(upd_set) < NUM_SET;
    assign lkp_ok = int'(lkp_set) < NUM_SET;

    // Next tree state for the touched set: each node points away from the
    // half that was touched, and is left alone if both or neither were.
    always_comb begin
        cur_tree = upd_ok ? tree_q[upd_set] : '0;
        upd_tree = cur_tree;
        lo_hit   = 1'b0;
        hi_hit   = 1'b0;
        for (int k = 0; k < NUM_WAY - 1; k++) begin
            lo_hit = 1'b0;
            hi_hit = 1'b0;
            for (int w = 0; w < NUM_WAY; w++) begin
                if (w >= node_lo(k, NUM_WAY) && w < node_lo(k, NUM_WAY) + node_size(k, NUM_WAY) / 2)
                    lo_hit = lo_hit | upd_way[w];
                if (w >= node_lo(k, NUM_WAY) + node_size(k, NUM_WAY) / 2 && w <= node_hi(k, NUM_WAY))
                    hi_hit = hi_hit | upd_way[w];
            end
            if (lo_hit && !hi_hit)      upd_tree[k] = 1'b1;
            else if (hi_hit && !lo_hit) upd_tree[k] = 1'b0;
        end
    end

    // Lookup sees the post-edge state: flush wins, then a same-set update.
    always_comb begin
        lkp_tree = lkp_ok ? tree_q[lkp_set] : '0;
        if (flush)
            lkp_tree = '0;
        else if (upd_en && upd_ok && (upd_set == lkp_set))
            lkp_tree = upd_tree;
    end

    plru_tree_pick #(
        .NUM_WAY (NUM_WAY)
    ) u_pick (
        .tree  (lkp_tree),
        .valid (lkp_valid),
        .lock  (lock),
        .way   (pick_way)
    );

    // Out-of-range lookups answer way 0; encode the one-hot result to binary.
    always_comb begin
        sel_way = lkp_ok ? pick_way : NUM_WAY'(1);
        sel_idx = '0;
        for (int w = 0; w < NUM_WAY; w++) begin
            if (sel_way[w]) sel_idx = WAY_W'(w);
        end
    end

    // Tree state array: reset/flush clear every set, otherwise apply the touch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SET; s++) tree_q[s] <= '0;
        end else if (flush) begin
            for (int s = 0; s < NUM_SET; s++) tree_q[s] <= '0;
        end else if (upd_en && upd_ok) begin
            tree_q[upd_set] <= upd_tree;
        end
    end

    // Registered victim result, valid for one cycle per lookup request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vic_vld <= 1'b0;
            vic_way <= '0;
            vic_idx <= '0;
`ifdef PLRU_WAY_LOCK_EN
            vic_none <= 1'b0;
`endif
        end else begin
            vic_vld <= lkp_en;
            if (lkp_en) begin
                vic_way <= sel_way;
                vic_idx <= sel_idx;
`ifdef PLRU_WAY_LOCK_EN
                vic_none <= lkp_ok && (&lkp_lock);
`endif
            end
        end
    end

endmodule
